// File: rtl/stream_arb_pkg.sv
// ---------------------------------------------------------------------------
// stream_arb_pkg
// Shared types for the stream round-robin arbiter.
//   arbState_t : arbiter FSM state (IDLE picks a requester, GRANT moves beats)
// ---------------------------------------------------------------------------
package stream_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arbState_t;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational cyclic first-set search.
// The result is the lowest set request index at or above ptr. If there is
// none, the search wraps and returns the lowest set index overall. This also
// covers a requester count that is not a power of two.
// Ports:
//   req : request vector, one bit per requester
//   ptr : search start index (always < NUM_REQ)
//   any : at least one request is set
//   idx : chosen requester index (0 when any is low)
// ---------------------------------------------------------------------------
module rr_pick
#(
    parameter int NUM_REQ    = 4,
    parameter int LB_NUM_REQ = $clog2(NUM_REQ)
)
(
    input  logic [NUM_REQ-1:0]    req,
    input  logic [LB_NUM_REQ-1:0] ptr,
    output logic                  any,
    output logic [LB_NUM_REQ-1:0] idx
);

    logic                  hiFound;
    logic [LB_NUM_REQ-1:0] hiIdx;
    logic [LB_NUM_REQ-1:0] loIdx;

    // The scan runs from the top index down, so the last hit written is
    // the lowest one. hiIdx only accepts hits at or above ptr. loIdx is
    // the wrap-around answer.
    always_comb begin
        hiFound = 1'b0;
        hiIdx   = '0;
        loIdx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                loIdx = LB_NUM_REQ'(i);
                if (LB_NUM_REQ'(i) >= ptr) begin
                    hiFound = 1'b1;
                    hiIdx   = LB_NUM_REQ'(i);
                end
            end
        end
    end

    assign any = |req;
    assign idx = hiFound ? hiIdx : loIdx;

endmodule

// File: rtl/stream_rr_arbiter.sv
// ---------------------------------------------------------------------------
// stream_rr_arbiter
// Shares one FIFO write port between NUM_REQ valid/ready producers. Grants
// are given in round-robin order and last for a burst of up to MAX_BURST
// beats. A grant ends early when the holder drops valid while the output
// stage could take a beat. The output stage holds one registered beat and
// tags it with the source index.
//
// Optional feature (macro ARB_PKT_MODE_EN): adds in_last/out_last. A grant
// is then released only on a beat flagged last. The burst limit and the
// idle release are ignored, so packets stay contiguous across valid gaps.
//
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset
//   in_data    : packed beats, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_valid   : per-requester valid
//   in_ready   : per-requester ready (only the granted bit can be high)
//   in_last    : per-requester packet end (ARB_PKT_MODE_EN only)
//   out_data   : registered beat to the FIFO
//   out_valid  : registered valid
//   out_ready  : FIFO in_ready
//   out_id     : source index of out_data
//   out_last   : registered packet end (ARB_PKT_MODE_EN only)
//   clear      : synchronous flush, overrides everything except reset
//   busy       : high while granting or while holding a beat
// ---------------------------------------------------------------------------
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4,
    localparam int LB_NUM_REQ = $clog2(NUM_REQ),
    localparam int LB_BURST   = $clog2(MAX_BURST + 1)
)
(
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_REQ-1:0]            in_valid,
    output logic [NUM_REQ-1:0]            in_ready,
`ifdef ARB_PKT_MODE_EN
    input  logic [NUM_REQ-1:0]            in_last,
    output logic                          out_last,
`endif
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LB_NUM_REQ-1:0]         out_id,
    input  logic                          clear,
    output logic                          busy
);

    arbState_t             state_q;
    logic [LB_NUM_REQ-1:0] rrPtr_q;
    logic [LB_NUM_REQ-1:0] grant_q;
    logic [LB_BURST-1:0]   burstCnt_q;
    logic                  outValid_q;
    logic [DATA_WIDTH-1:0] outData_q;
    logic [LB_NUM_REQ-1:0] outId_q;

    logic                  pickAny;
    logic [LB_NUM_REQ-1:0] pickIdx;
    logic [LB_NUM_REQ-1:0] nextPtr;
    logic [DATA_WIDTH-1:0] selData;
    logic                  selValid;
    logic                  stageFree;
    logic                  beat;
    logic                  grantDone;
    logic [NUM_REQ-1:0]    inReady;

`ifdef ARB_PKT_MODE_EN
    logic                  selLast;
    logic                  outLast_q;
`endif

    rr_pick #(
        .NUM_REQ    (NUM_REQ),
        .LB_NUM_REQ (LB_NUM_REQ)
    ) u_pick (
        .req (in_valid),
        .ptr (rrPtr_q),
        .any (pickAny),
        .idx (pickIdx)
    );

    // Route the granted requester's beat and handshake bits through a mux
    // built from equality compares. This avoids a variable part-select on
    // the packed input bus.
    always_comb begin
        selData  = '0;
        selValid = 1'b0;
`ifdef ARB_PKT_MODE_EN
        selLast  = 1'b0;
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == LB_NUM_REQ'(i)) begin
                selData  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                selValid = in_valid[i];
`ifdef ARB_PKT_MODE_EN
                selLast  = in_last[i];
`endif
            end
        end
    end

    assign stageFree = ~outValid_q | out_ready;
    assign beat      = (state_q == GRANT) & selValid & stageFree;
    assign nextPtr   = (grant_q == LB_NUM_REQ'(NUM_REQ - 1)) ? '0
                                                              : grant_q + LB_NUM_REQ'(1);

`ifdef ARB_PKT_MODE_EN
    assign grantDone = beat & selLast;
`else
    // The idle release waits for stageFree. A holder that drops valid
    // during a stall keeps its grant.
    assign grantDone = (beat & (burstCnt_q == LB_BURST'(MAX_BURST - 1)))
                     | (stageFree & ~selValid);
`endif

    // Only the holder sees ready, and only when the stage can take a beat.
    always_comb begin
        inReady = '0;
        if (state_q == GRANT) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_q == LB_NUM_REQ'(i)) begin
                    inReady[i] = stageFree;
                end
            end
        end
    end

    // Arbiter FSM and output stage. A beat always refills the register,
    // because a beat is only possible when the stage is empty or draining.
    // A release sets up the new rr_ptr. The next pick uses it in the
    // following IDLE cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            rrPtr_q    <= '0;
            grant_q    <= '0;
            burstCnt_q <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outId_q    <= '0;
`ifdef ARB_PKT_MODE_EN
            outLast_q  <= 1'b0;
`endif
        end else if (clear) begin
            state_q    <= IDLE;
            rrPtr_q    <= '0;
            grant_q    <= '0;
            burstCnt_q <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outId_q    <= '0;
`ifdef ARB_PKT_MODE_EN
            outLast_q  <= 1'b0;
`endif
        end else begin
            if (beat) begin
                outValid_q <= 1'b1;
                outData_q  <= selData;
                outId_q    <= grant_q;
`ifdef ARB_PKT_MODE_EN
                outLast_q  <= selLast;
`endif
            end else if (out_ready) begin
                outValid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (pickAny) begin
                        grant_q    <= pickIdx;
                        burstCnt_q <= '0;
                        state_q    <= GRANT;
                    end
                end
                GRANT: begin
                    if (beat) begin
                        burstCnt_q <= burstCnt_q + LB_BURST'(1);
                    end
                    if (grantDone) begin
                        state_q <= IDLE;
                        rrPtr_q <= nextPtr;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = inReady;
    assign out_data  = outData_q;
    assign out_valid = outValid_q;
    assign out_id    = outId_q;
    assign busy      = (state_q == GRANT) | outValid_q;
`ifdef ARB_PKT_MODE_EN
    assign out_last  = outLast_q;
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_stream_rr_arbiter
// Directed bench for stream_rr_arbiter.
// dut4 uses the default build (4 requesters, bursts of 4) and is driven
// from per-requester beat queues. dut3 uses 3 requesters with bursts of 1.
// All three of its requesters are always valid, so it shows the
// one-beat-per-grant rotation and the 2 -> 0 pointer wrap.
// With ARB_PKT_MODE_EN defined, the packet test runs in place of the
// burst-count tests.
// ---------------------------------------------------------------------------
module tb_stream_rr_arbiter;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    // dut4 signals
    logic [31:0] inData4   = '0;
    logic [3:0]  inValid4  = '0;
    logic [3:0]  inReady4;
    logic [7:0]  outData4;
    logic        outValid4;
    logic        outReady4 = 1'b1;
    logic [1:0]  outId4;
    logic        clear4    = 1'b0;
    logic        busy4;

    // dut3 signals
    logic [23:0] inData3   = {8'hA2, 8'hA1, 8'hA0};
    logic [2:0]  inValid3  = 3'b111;
    logic [2:0]  inReady3;
    logic [7:0]  outData3;
    logic        outValid3;
    logic        outReady3 = 1'b1;
    logic [1:0]  outId3;
    logic        clear3    = 1'b0;
    logic        busy3;

`ifdef ARB_PKT_MODE_EN
    logic [3:0]  inLast4   = '0;
    logic        outLast4;
    logic [2:0]  inLast3   = 3'b111;
    logic        outLast3;
`endif

    stream_rr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(4)) dut4 (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (inData4),
        .in_valid  (inValid4),
        .in_ready  (inReady4),
`ifdef ARB_PKT_MODE_EN
        .in_last   (inLast4),
        .out_last  (outLast4),
`endif
        .out_data  (outData4),
        .out_valid (outValid4),
        .out_ready (outReady4),
        .out_id    (outId4),
        .clear     (clear4),
        .busy      (busy4)
    );

    stream_rr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(3), .MAX_BURST(1)) dut3 (
        .clk       (clk),
        .rstn      (rstn),
        .in_data   (inData3),
        .in_valid  (inValid3),
        .in_ready  (inReady3),
`ifdef ARB_PKT_MODE_EN
        .in_last   (inLast3),
        .out_last  (outLast3),
`endif
        .out_data  (outData3),
        .out_valid (outValid3),
        .out_ready (outReady3),
        .out_id    (outId3),
        .clear     (clear3),
        .busy      (busy3)
    );

    int checks = 0;
    int errors = 0;

    // Per-requester beat queues. The test process owns the tails and the
    // memories. The driver owns the heads.
    logic [7:0] srcData [4][16];
    logic       srcLast [4][16];
    int         srcHead [4] = '{default: 0};
    int         srcTail [4] = '{default: 0};
    logic [3:0] holdMask    = '0;
    logic       outReadyCtl = 1'b1;

    // Accepted output beats, as recorded by the driver.
    logic [1:0] obsId   [128];
    logic [7:0] obsData [128];
    logic       obsLast [128];
    int         obsCycle[128];
    int         obsCount  = 0;
    int         obsBase   = 0;
    int         cycleCnt  = 0;
    int         lastRise  = 0;

    logic [1:0] obs3Id   [6];
    logic [7:0] obs3Data [6];
    int         obs3Count = 0;

    int rotId [20] = '{0,0,0,0, 1,1,1,1, 2,2,2,2, 3,3,3,3, 0,0,0,0};
    int dut3Id[6]  = '{0, 1, 2, 0, 1, 2};

    // dut4 driver and monitor. Handshakes and accepted beats are sampled at
    // the falling edge. New inputs are applied 1 ns after the rising edge.
    always begin
        logic [3:0] prevValid;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (inValid4[i] && inReady4[i] && srcHead[i] < srcTail[i]) begin
                srcHead[i] = srcHead[i] + 1;
            end
        end
        if (outValid4 && outReady4 && obsCount < 128) begin
            obsId[obsCount]    = outId4;
            obsData[obsCount]  = outData4;
`ifdef ARB_PKT_MODE_EN
            obsLast[obsCount]  = outLast4;
`else
            obsLast[obsCount]  = 1'b0;
`endif
            obsCycle[obsCount] = cycleCnt;
            obsCount = obsCount + 1;
        end
        @(posedge clk);
        #1;
        cycleCnt  = cycleCnt + 1;
        outReady4 = outReadyCtl;
        prevValid = inValid4;
        for (int i = 0; i < 4; i++) begin
            if (srcHead[i] < srcTail[i] && !holdMask[i]) begin
                inValid4[i]         = 1'b1;
                inData4[i*8 +: 8]   = srcData[i][srcHead[i] % 16];
`ifdef ARB_PKT_MODE_EN
                inLast4[i]          = srcLast[i][srcHead[i] % 16];
`endif
            end else begin
                inValid4[i]         = 1'b0;
                inData4[i*8 +: 8]   = 8'h00;
`ifdef ARB_PKT_MODE_EN
                inLast4[i]          = 1'b0;
`endif
            end
        end
        if (prevValid == 4'b0000 && inValid4 != 4'b0000) begin
            lastRise = cycleCnt;
        end
    end

    // dut3 monitor: captures the first six accepted beats.
    always begin
        @(negedge clk);
        if (outValid3 && outReady3 && obs3Count < 6) begin
            obs3Id[obs3Count]   = outId3;
            obs3Data[obs3Count] = outData3;
            obs3Count = obs3Count + 1;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int req, input logic [7:0] data, input logic last);
        srcData[req][srcTail[req] % 16] = data;
        srcLast[req][srcTail[req] % 16] = last;
        srcTail[req] = srcTail[req] + 1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic flushQueues();
        for (int i = 0; i < 4; i++) srcTail[i] = srcHead[i];
        holdMask = '0;
    endtask

    task automatic doReset();
        rstn = 1'b0;
        tick(1);
        rstn = 1'b1;
        tick(1);
    endtask

    task automatic waitObs(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (obsCount - obsBase < n && k < budget) begin
            tick(1);
            k++;
        end
        if (obsCount - obsBase < n) begin
            checkOutput(tag, obsCount - obsBase, n);
        end
    endtask

    task automatic checkObs(input string tag, input int k, input int id,
                            input int data);
        checkOutput($sformatf("%s_id%0d", tag, k), obsId[obsBase + k], id);
        checkOutput($sformatf("%s_data%0d", tag, k), obsData[obsBase + k], data);
    endtask

    initial begin
        $display("[TB] start");
        tick(2);
        checkOutput("rst_outValid", outValid4, 0);
        checkOutput("rst_inReady", inReady4, 0);
        checkOutput("rst_busy", busy4, 0);
        checkOutput("rst_outData", outData4, 0);
        checkOutput("rst_outId", outId4, 0);
        rstn = 1'b1;
        tick(1);

`ifndef ARB_PKT_MODE_EN
        // Single requester: two bursts of four with one bubble between them
        obsBase = obsCount;
        for (int k = 0; k < 8; k++) applyStimulus(2, 8'(8'h10 + k), k == 7);
        waitObs(8, 60, "t1_timeout");
        for (int k = 0; k < 8; k++) checkObs("t1", k, 2, 8'h10 + k);
        checkOutput("t1_latency", obsCycle[obsBase] - lastRise, 2);
        checkOutput("t1_b2b", obsCycle[obsBase + 1] - obsCycle[obsBase], 1);
        checkOutput("t1_bubble", obsCycle[obsBase + 4] - obsCycle[obsBase + 3], 2);
        tick(3);
        for (int k = 0; k < 4; k++) begin
            checkOutput("t1_idleValid", outValid4, 0);
            checkOutput("t1_idleReady", inReady4, 0);
            tick(1);
        end

        // Rotation: all four requesters continuously valid
        doReset();
        obsBase = obsCount;
        for (int k = 0; k < 8; k++) applyStimulus(0, 8'(k), k == 7);
        for (int r = 1; r < 4; r++)
            for (int k = 0; k < 4; k++) applyStimulus(r, 8'((r << 4) + k), k == 3);
        waitObs(20, 120, "t2_timeout");
        for (int k = 0; k < 20; k++)
            checkObs("t2", k, rotId[k], (rotId[k] << 4) + ((k < 16) ? (k % 4) : (4 + k % 4)));

        // Early release: req1 sends two beats and drops valid; req3 pending
        doReset();
        obsBase = obsCount;
        applyStimulus(1, 8'h11, 1'b0);
        applyStimulus(1, 8'h12, 1'b1);
        applyStimulus(3, 8'h31, 1'b0);
        applyStimulus(3, 8'h32, 1'b1);
        waitObs(3, 40, "t3_timeout");
        checkOutput("t3_rrPtr", dut4.rrPtr_q, 2);
        waitObs(4, 40, "t3_timeout2");
        checkObs("t3", 0, 1, 8'h11);
        checkObs("t3", 1, 1, 8'h12);
        checkObs("t3", 2, 3, 8'h31);
        checkObs("t3", 3, 3, 8'h32);

        // Backpressure mid-burst, with the holder dropping valid while stalled
        doReset();
        obsBase = obsCount;
        for (int k = 0; k < 4; k++) applyStimulus(0, 8'(8'hA0 + k), k == 3);
        applyStimulus(2, 8'hC0, 1'b1);
        waitObs(1, 40, "t4_timeout");
        outReadyCtl = 1'b0;
        holdMask    = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            checkOutput("t4_stallValid", outValid4, 1);
            checkOutput("t4_stallData", outData4, 8'hA2);
            checkOutput("t4_stallId", outId4, 0);
            checkOutput("t4_stallReady", inReady4, 0);
        end
        outReadyCtl = 1'b1;
        holdMask    = 4'b0000;
        waitObs(5, 40, "t4_timeout2");
        for (int k = 0; k < 4; k++) checkObs("t4", k, 0, 8'hA0 + k);
        checkObs("t4", 4, 2, 8'hC0);
`endif

        // clear during GRANT with a beat held in the stage
        doReset();
        obsBase = obsCount;
        applyStimulus(1, 8'h61, 1'b1);
        for (int k = 0; k < 4; k++) applyStimulus(2, 8'(8'h62 + k), k == 3);
        waitObs(2, 40, "t5_timeout");
        checkObs("t5", 0, 1, 8'h61);
        checkObs("t5", 1, 2, 8'h62);
        checkOutput("t5_validPre", outValid4, 1);
        checkOutput("t5_busyPre", busy4, 1);
        clear4 = 1'b1;
        flushQueues();
        tick(1);
        checkOutput("t5_clrValid", outValid4, 0);
        checkOutput("t5_clrBusy", busy4, 0);
        checkOutput("t5_clrReady", inReady4, 0);
        checkOutput("t5_clrData", outData4, 0);
        checkOutput("t5_clrId", outId4, 0);
        tick(1);
        clear4 = 1'b0;
        obsBase = obsCount;
        applyStimulus(1, 8'h51, 1'b1);
        applyStimulus(3, 8'h53, 1'b1);
        waitObs(2, 40, "t5_timeout2");
        checkObs("t5post", 0, 1, 8'h51);
        checkObs("t5post", 1, 3, 8'h53);

`ifdef ARB_PKT_MODE_EN
        // Six-beat packet with a two-cycle valid gap stays contiguous
        doReset();
        obsBase = obsCount;
        for (int k = 0; k < 6; k++) applyStimulus(0, 8'(8'h70 + k), k == 5);
        applyStimulus(1, 8'h81, 1'b1);
        waitObs(2, 40, "t6_timeout");
        holdMask = 4'b0001;
        tick(2);
        holdMask = 4'b0000;
        waitObs(7, 60, "t6_timeout2");
        for (int k = 0; k < 6; k++) begin
            checkObs("t6", k, 0, 8'h70 + k);
            checkOutput($sformatf("t6_last%0d", k), obsLast[obsBase + k], k == 5);
        end
        checkObs("t6", 6, 1, 8'h81);
        checkOutput("t6_last6", obsLast[obsBase + 6], 1);
`endif

        // Asynchronous reset in the middle of a burst
        obsBase = obsCount;
        for (int k = 0; k < 4; k++) applyStimulus(0, 8'(8'h90 + k), k == 3);
        waitObs(1, 40, "t7_timeout");
        checkOutput("t7_validPre", outValid4, 1);
        #1;
        rstn = 1'b0;
        #1;
        checkOutput("t7_rstValid", outValid4, 0);
        checkOutput("t7_rstReady", inReady4, 0);
        checkOutput("t7_rstBusy", busy4, 0);
        checkOutput("t7_rstData", outData4, 0);
        checkOutput("t7_rstId", outId4, 0);
        flushQueues();
        tick(1);
        rstn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            checkOutput("t7_idleValid", outValid4, 0);
            checkOutput("t7_idleReady", inReady4, 0);
        end

        // dut3: one beat per grant, pointer wraps 2 -> 0
        if (obs3Count < 6) checkOutput("d3_timeout", obs3Count, 6);
        for (int k = 0; k < obs3Count; k++) begin
            checkOutput($sformatf("d3_id%0d", k), obs3Id[k], dut3Id[k]);
            checkOutput($sformatf("d3_data%0d", k), obs3Data[k], 8'hA0 + dut3Id[k]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Shares one sync_fifo write port (in_data/in_valid/in_ready) between NUM_REQ independent valid/ready producers.
- Round-robin grant, held for a burst of up to MAX_BURST beats; grant released early when the holder drops valid.
- Registered single-entry output stage connects directly to the FIFO input, with the source id tagged on out_id.

Parameters:
- DATA_WIDTH, 8, beat width.
- NUM_REQ, 4, requester count (>=2, need not be a power of two).
- MAX_BURST, 4, maximum beats per grant (>=1).
- localparam LB_NUM_REQ = $clog2(NUM_REQ); LB_BURST = $clog2(MAX_BURST+1).

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- in_data  input  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_valid  input  NUM_REQ  per-requester valid
- in_ready  output  NUM_REQ  per-requester ready
- out_data  output  DATA_WIDTH  registered beat to FIFO
- out_valid  output  1  registered valid
- out_ready  input  1  FIFO in_ready
- out_id  output  LB_NUM_REQ  source index of out_data
- clear  input  1  synchronous flush, same role as in sync_fifo
- busy  output  1  high while state is GRANT or out_valid is high

Behaviour:
- Reset (rstn low, async) and clear (sync, priority over everything): state=IDLE, rr_ptr=0, grant_r=0, burst_cnt=0, out_valid=0, out_data=0, out_id=0, in_ready=0.
- stage_free = ~out_valid | out_ready.
- States:
  - IDLE: in_ready all 0. If any in_valid, grant_r = first index i >= rr_ptr with in_valid[i], searching cyclically. Then burst_cnt=0 and move to GRANT. Otherwise stay in IDLE.
  - GRANT: in_ready[grant_r] = stage_free; all other bits 0.
- Beat: in_valid[g] & in_ready[g] with g = grant_r.
  - Loads out_data/out_id, sets out_valid=1, burst_cnt++.
  - If out_valid & out_ready with no new beat: out_valid=0.
- Release from GRANT to IDLE, setting rr_ptr = (g==NUM_REQ-1) ? 0 : g+1, when either:
  - (a) a beat occurs with burst_cnt==MAX_BURST-1; or
  - (b) stage_free & ~in_valid[g] (holder idle while it could send).
- No release when the stage is stalled, even if in_valid[g] drops.
- Latency: in_valid rising in IDLE gives the earliest beat accept 1 cycle later and out_valid 2 cycles after the request. One IDLE bubble cycle per grant.
- Fairness: a requester that keeps valid high waits at most (NUM_REQ-1)*(MAX_BURST+1) cycles of unstalled output.
- MAX_BURST=1: every beat releases.
- Simultaneous release and new requests: the new pick happens in the following IDLE cycle using the updated rr_ptr.
- The output stage never drops or duplicates a beat. out_data/out_id are stable while out_valid & ~out_ready.

Optional Feature:
- Macro ARB_PKT_MODE_EN.
- Defined:
  - Adds ports in_last [NUM_REQ] and out_last [1], registered alongside out_data.
  - Release only on a beat with in_last[g]=1; MAX_BURST and rule (b) are ignored, so grant is held across valid gaps to keep packets contiguous.
  - out_last resets to 0.
- Undefined: ports absent; count/idle release as above.

Decomposition:
- Package stream_arb_pkg: state enum (IDLE, GRANT) typedef.
- Sub-module rr_pick (combinational): inputs req [NUM_REQ], ptr [LB_NUM_REQ]; outputs any, idx [LB_NUM_REQ]. Implements the cyclic first-set search, including the non-power-of-two wrap.

Test Plan:
- Reset/idle: rstn low mid-burst → all outputs 0 immediately; after release, in_valid=0 → in_ready=0, out_valid=0 forever.
- Single requester: req2 streams 0x10..0x17, out_ready=1, MAX_BURST=4 → out_data 0x10..0x13 with out_id=2, one bubble, 0x14..0x17; all beats in order.
- Rotation: all four valid continuously, NUM_REQ=4 → out_id sequence 0000 1111 2222 3333 0000; rr_ptr wraps 3→0. Repeat with NUM_REQ=3: wraps 2→0.
- Early release: req1 sends 2 beats then drops valid, req3 pending → grant moves to req3 after 2 beats; next rr_ptr=2.
- Backpressure: out_ready low 5 cycles mid-burst → out_data/out_id held, in_ready[g]=0, no release on valid drop. On out_ready=1, beats resume with none lost.
- clear during GRANT with out_valid=1 → next cycle out_valid=0, state IDLE, rr_ptr=0. With ARB_PKT_MODE_EN: a 6-beat packet from req0 is uninterrupted despite a 2-cycle valid gap, and out_last=1 only on beat 6.
